jtag_bus_master: RTL and testbench

JTAG_BUS_MASTER -- requirements
Module: jtag_bus_master

---
 rtl/jtag_bus_master.sv | 223 ++++++++++++++++++++++
 tb/tb_jtag_bus_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_bus_master.sv
// jtag_bus_master
// Moves one burst between a local ping-pong buffer and the system bus,
// started by a command arriving from the JTAG chain1 clock domain.
//   read  command: bus -> buffer, one buffer write per dataValidIn beat
//   write command: buffer -> bus, one bus beat per non-busy cycle
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   cmd_*                 command fields, latched on cmd_valid while idle
//   cmd_ready             high only while idle
//   done                  one-cycle completion pulse (success or error)
//   bus_error             sticky error flag, cleared by the next accepted command
//   buf_addr/we/wdata     buffer port; buf_rdata returns one cycle after buf_addr
//   requestTransaction .. busyIn   bus master interface
//   dbg_state             current FSM state, for observation only
//
// Handshake: a command is taken in the cycle where cmd_valid and cmd_ready
// are both high; cmd_valid in any other cycle has no effect.
//
// Build option: define JTAG_BUS_TIMEOUT_EN to add a watchdog that aborts to
// ERROR after TIMEOUT_CYC idle cycles waiting for grant, read data or a
// busy slave. Without it the block waits indefinitely.
module jtag_bus_master #(
  parameter int BUF_AW      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_read,
  input  logic [31:0]       cmd_address,
  input  logic [3:0]        cmd_byte_enables,
  input  logic [7:0]        cmd_burst_size,
  output logic              cmd_ready,
  output logic              done,
  output logic              bus_error,
  output logic [BUF_AW-1:0] buf_addr,
  output logic              buf_we,
  output logic [31:0]       buf_wdata,
  input  logic [31:0]       buf_rdata,
  output logic              requestTransaction,
  input  logic              transactionGranted,
  output logic              beginTransactionOut,
  output logic [31:0]       addressDataOut,
  output logic [3:0]        byteEnablesOut,
  output logic [7:0]        burstSizeOut,
  output logic              readNotWriteOut,
  output logic              endTransactionOut,
  output logic              dataValidOut,
  input  logic [31:0]       addressDataIn,
  input  logic              dataValidIn,
  input  logic              endTransactionIn,
  input  logic              busErrorIn,
  input  logic              busyIn,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQUEST    = 3'd1,
    BEGIN      = 3'd2,
    READ_DATA  = 3'd3,
    WRITE_PRE  = 3'd4,
    WRITE_DATA = 3'd5,
    END        = 3'd6,
    ERROR      = 3'd7
  } state_t;

  state_t      state, state_nxt;
  logic        lat_read;
  logic [31:0] lat_addr;
  logic [3:0]  lat_be;
  logic [7:0]  lat_burst;
  logic [7:0]  beat_cnt;
  logic [7:0]  beat_nxt;
  logic        beat_inc;
  logic        last_beat;
  logic        wd_hit;

  assign beat_nxt  = beat_cnt + 8'd1;
  assign last_beat = (beat_cnt == lat_burst);
  assign dbg_state = state;
  // Gated by reset so every output reads 0 while reset is held.
  assign cmd_ready = (state == IDLE) && !reset;

`ifdef JTAG_BUS_TIMEOUT_EN
  logic [31:0] wd_cnt;
  assign wd_hit = (wd_cnt >= 32'(TIMEOUT_CYC));

  // Counts only cycles spent waiting on the bus; any other state or an
  // accepted beat restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if ((state_nxt == REQUEST && state != REQUEST) || beat_inc) begin
      wd_cnt <= '0;
    end else if (state == REQUEST || state == READ_DATA ||
                 (state == WRITE_DATA && busyIn)) begin
      wd_cnt <= wd_cnt + 32'd1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  logic unused_timeout;
  assign wd_hit         = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_nxt           = state;
    beat_inc            = 1'b0;
    done                = 1'b0;
    buf_addr            = '0;
    buf_we              = 1'b0;
    buf_wdata           = '0;
    requestTransaction  = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = '0;
    byteEnablesOut      = '0;
    burstSizeOut        = '0;
    readNotWriteOut     = 1'b0;
    endTransactionOut   = 1'b0;
    dataValidOut        = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = REQUEST;
      end
      REQUEST: begin
        requestTransaction = 1'b1;
        if (transactionGranted) begin
          state_nxt = BEGIN;
        end else if (wd_hit) begin
          requestTransaction = 1'b0;
          state_nxt          = ERROR;
        end
      end
      BEGIN: begin
        beginTransactionOut = 1'b1;
        addressDataOut      = lat_addr;
        byteEnablesOut      = lat_be;
        burstSizeOut        = lat_burst;
        readNotWriteOut     = lat_read;
        if (busErrorIn)    state_nxt = ERROR;
        else if (lat_read) state_nxt = READ_DATA;
        else               state_nxt = WRITE_PRE;
      end
      READ_DATA: begin
        buf_addr  = BUF_AW'(beat_cnt);
        buf_wdata = addressDataIn;
        // The slave may end the burst only together with the final beat;
        // an error in the same cycle as a beat discards that beat.
        if (busErrorIn || (endTransactionIn && !(dataValidIn && last_beat))) begin
          state_nxt = ERROR;
        end else if (dataValidIn) begin
          buf_we   = 1'b1;
          beat_inc = 1'b1;
          if (last_beat) state_nxt = END;
        end else if (wd_hit) begin
          state_nxt = ERROR;
        end
      end
      WRITE_PRE: begin
        // Present word 0 so buf_rdata holds it on the first data cycle.
        buf_addr = BUF_AW'(beat_cnt);
        if (busErrorIn) state_nxt = ERROR;
        else            state_nxt = WRITE_DATA;
      end
      WRITE_DATA: begin
        dataValidOut   = 1'b1;
        addressDataOut = buf_rdata;
        buf_addr       = BUF_AW'(beat_cnt);
        if (busErrorIn) begin
          state_nxt = ERROR;
        end else if (!busyIn) begin
          // Beat accepted: fetch the next word now so it is ready next cycle.
          buf_addr = BUF_AW'(beat_nxt);
          beat_inc = 1'b1;
          if (last_beat) state_nxt = END;
        end else if (wd_hit) begin
          state_nxt = ERROR;
        end
      end
      END: begin
        done              = 1'b1;
        endTransactionOut = !lat_read;
        state_nxt         = IDLE;
      end
      ERROR: begin
        done              = 1'b1;
        endTransactionOut = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_read  <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_burst <= '0;
      beat_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        lat_read  <= cmd_read;
        lat_addr  <= cmd_address;
        lat_be    <= cmd_byte_enables;
        lat_burst <= cmd_burst_size;
        beat_cnt  <= '0;
        bus_error <= 1'b0;
      end else if (beat_inc) begin
        beat_cnt <= beat_nxt;
      end
      if (state_nxt == ERROR) bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_bus_master.sv
// Testbench for jtag_bus_master: drives randomized and directed bursts
// through a slave model and a buffer RAM model, and checks the DUT against
// per-transaction expectations (begin fields, buffer writes, bus beats,
// completion counts, error flag).
module tb_jtag_bus_master;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_read;
  logic [31:0]   cmd_address;
  logic [3:0]    cmd_byte_enables;
  logic [7:0]    cmd_burst_size;
  logic          cmd_ready, done, bus_error;
  logic [AW-1:0] buf_addr;
  logic          buf_we;
  logic [31:0]   buf_wdata, buf_rdata;
  logic          requestTransaction, transactionGranted, beginTransactionOut;
  logic [31:0]   addressDataOut, addressDataIn;
  logic [3:0]    byteEnablesOut;
  logic [7:0]    burstSizeOut;
  logic          readNotWriteOut, endTransactionOut, dataValidOut;
  logic          dataValidIn, endTransactionIn, busErrorIn, busyIn;
  logic [2:0]    dbg_state;

  jtag_bus_master #(.BUF_AW(AW), .TIMEOUT_CYC(255)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_read(cmd_read), .cmd_address(cmd_address),
    .cmd_byte_enables(cmd_byte_enables), .cmd_burst_size(cmd_burst_size),
    .cmd_ready(cmd_ready), .done(done), .bus_error(bus_error),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
    .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
    .byteEnablesOut(byteEnablesOut), .burstSizeOut(burstSizeOut),
    .readNotWriteOut(readNotWriteOut), .endTransactionOut(endTransactionOut),
    .dataValidOut(dataValidOut), .addressDataIn(addressDataIn),
    .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn),
    .busErrorIn(busErrorIn), .busyIn(busyIn), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- buffer RAM model (1-cycle read latency) ----------------
  logic [31:0] mem [0:255];
  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [31:0] tb_data;
  always @(posedge clock) begin
    if (tb_we)       mem[tb_addr]  <= tb_data;
    else if (buf_we) mem[buf_addr] <= buf_wdata;
    buf_rdata <= mem[buf_addr];
  end

  // ---------------- scoreboard ----------------
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [AW+31:0] exp_wr_q[$];
  logic [31:0]    exp_q[$];
  logic [31:0]    got_bus[$];
  int             done_cnt, endtx_cnt, begin_cnt, hold22_cnt;
  logic [31:0]    eb_addr;
  logic [3:0]     eb_be;
  logic [7:0]     eb_burst;
  logic           eb_read;
  logic [31:0]    wdat [0:255];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (endTransactionOut) endtx_cnt++;
      if (beginTransactionOut) begin
        begin_cnt++;
        check("begin_addr", addressDataOut, eb_addr);
        check("begin_be", byteEnablesOut, eb_be);
        check("begin_burst", burstSizeOut, eb_burst);
        check("begin_rnw", readNotWriteOut, eb_read);
        check("begin_quiet", {requestTransaction, dataValidOut, endTransactionOut, done, buf_we}, 0);
      end
      if (buf_we) begin
        if (exp_wr_q.size() == 0) check("buf_write_unexpected", {buf_addr, buf_wdata}, 0);
        else check("buf_write", {buf_addr, buf_wdata}, exp_wr_q.pop_front());
      end
      if (dataValidOut) begin
        if (exp_q.size() == 0) begin
          check("bus_beat_unexpected", addressDataOut, 0);
        end else begin
          check("bus_beat", addressDataOut, exp_q[0]);
          if (addressDataOut == 32'h22222222) hold22_cnt++;
          if (!busyIn && !busErrorIn) begin
            got_bus.push_back(addressDataOut);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_bus_inputs();
    dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0; busyIn = 0;
    transactionGranted = 0; addressDataIn = 0;
  endtask

  task automatic issue(input logic rd, input logic [31:0] addr, input logic [3:0] be, input int burst);
    eb_addr = addr; eb_be = be; eb_burst = 8'(burst); eb_read = rd;
    done_cnt = 0; endtx_cnt = 0; begin_cnt = 0; hold22_cnt = 0;
    got_bus.delete();
    cmd_read = rd; cmd_address = addr; cmd_byte_enables = be; cmd_burst_size = 8'(burst);
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    check("accept_not_ready", cmd_ready, 0);
    check("accept_clears_error", bus_error, 0);
  endtask

  // Grant after 'delay' cycles; junk commands are pulsed meanwhile and must
  // not disturb the latched fields checked at begin.
  task automatic grant(input int delay);
    for (int i = 0; i < delay; i++) begin
      check("request_held", requestTransaction, 1);
      if (i % 2 == 0) begin
        cmd_valid = 1; cmd_read = ~eb_read; cmd_address = $urandom;
        cmd_byte_enables = 4'($urandom); cmd_burst_size = 8'($urandom);
      end
      step();
      cmd_valid = 0;
    end
    check("request_at_grant", requestTransaction, 1);
    transactionGranted = 1;
    step();
    transactionGranted = 0;
    step();
  endtask

  task automatic finish_txn(input int exp_endtx, input logic exp_err, input int exp_left);
    check("done_count", done_cnt, 1);
    check("endtx_count", endtx_cnt, exp_endtx);
    check("begin_count", begin_cnt, 1);
    check("bus_error", bus_error, exp_err);
    check("ready_after", cmd_ready, 1);
    check("wr_q_left", exp_wr_q.size(), 0);
    check("bus_q_left", exp_q.size(), exp_left);
    exp_wr_q.delete();
    exp_q.delete();
  endtask

  // err_beat < 0: no error. kind 0: busErrorIn; kind 1: early endTransactionIn.
  task automatic read_txn(input logic [31:0] addr, input int burst, input int delay,
                          input int err_beat, input int kind, input logic directed);
    logic [31:0] d;
    issue(1'b1, addr, 4'($urandom), burst);
    grant(delay);
    for (int i = 0; i <= burst; i++) begin
      d = directed ? 32'(32'hA0 + i) : $urandom;
      if (!directed) repeat ($urandom_range(0, 2)) step();
      addressDataIn = d;
      if (i == err_beat) begin
        if (kind == 0) begin
          busErrorIn = 1; dataValidIn = 1'($urandom_range(0, 1));
        end else begin
          endTransactionIn = 1; dataValidIn = 1;
        end
        step();
        clear_bus_inputs();
        break;
      end
      exp_wr_q.push_back({8'(i), d});
      dataValidIn = 1;
      endTransactionIn = (i == burst) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      clear_bus_inputs();
    end
    step();
    finish_txn(err_beat >= 0 ? 1 : 0, err_beat >= 0, 0);
  endtask

  // busy1 >= 0: exactly busy1 busy cycles on beat 1 only; otherwise random.
  task automatic write_txn(input logic [31:0] addr, input int burst, input int delay,
                           input int err_beat, input int busy1);
    for (int i = 0; i <= burst; i++) begin
      tb_we = 1; tb_addr = 8'(i); tb_data = wdat[i];
      step();
      if (err_beat < 0 || i <= err_beat) exp_q.push_back(wdat[i]);
    end
    tb_we = 0;
    issue(1'b0, addr, 4'($urandom), burst);
    grant(delay);
    step();
    for (int i = 0; i <= burst; i++) begin
      int nb;
      nb = (busy1 >= 0) ? ((i == 1) ? busy1 : 0) : $urandom_range(0, 2);
      busyIn = 1;
      repeat (nb) step();
      busyIn = 0;
      if (i == err_beat) begin
        busErrorIn = 1;
        step();
        clear_bus_inputs();
        break;
      end
      step();
    end
    clear_bus_inputs();
    step();
    finish_txn(1, err_beat >= 0, err_beat >= 0 ? 1 : 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1; cmd_valid = 0; cmd_read = 0; cmd_address = 0;
    cmd_byte_enables = 0; cmd_burst_size = 0; tb_we = 0; tb_addr = 0; tb_data = 0;
    clear_bus_inputs();
    #1;
    check("reset_outs_a", {cmd_ready, done, bus_error, buf_we, requestTransaction,
                           beginTransactionOut, readNotWriteOut, endTransactionOut,
                           dataValidOut, buf_addr, byteEnablesOut, burstSizeOut, dbg_state}, 0);
    check("reset_outs_b", {buf_wdata, addressDataOut}, 0);
    step(); step();
    reset = 0;
    step();
    check("ready_after_reset", cmd_ready, 1);

    // Directed read: 4 beats 0xA0..0xA3 into buffer 0..3.
    read_txn(32'h00001000, 3, 2, -1, 0, 1'b1);
    check("mem0", mem[0], 32'hA0);
    check("mem1", mem[1], 32'hA1);
    check("mem2", mem[2], 32'hA2);
    check("mem3", mem[3], 32'hA3);

    // Directed write with beat 1 held busy for 2 cycles.
    wdat[0] = 32'h11111111; wdat[1] = 32'h22222222;
    write_txn(32'h00002000, 1, 1, -1, 2);
    check("wr_word0", got_bus.size() > 0 ? got_bus[0] : 32'hX, 32'h11111111);
    check("wr_word1", got_bus.size() > 1 ? got_bus[1] : 32'hX, 32'h22222222);
    check("wr_hold_cycles", hold22_cnt, 3);

    // Read of 8 beats with bus error at beat 2; next command clears the flag.
    read_txn(32'h00003000, 7, 0, 2, 0, 1'b0);
    // Early slave end before the final beat counts as an error.
    read_txn(32'h00003100, 5, 1, 3, 1, 1'b0);

    // Reset in the middle of a read at beat 5.
    issue(1'b1, 32'h00004000, 4'hF, 7);
    grant(1);
    for (int i = 0; i < 5; i++) begin
      addressDataIn = $urandom;
      exp_wr_q.push_back({8'(i), addressDataIn});
      dataValidIn = 1;
      step();
      clear_bus_inputs();
    end
    dataValidIn = 1; addressDataIn = 32'hDEADBEEF;
    reset = 1;
    #1;
    check("midreset_outs_a", {cmd_ready, done, bus_error, buf_we, requestTransaction,
                              beginTransactionOut, readNotWriteOut, endTransactionOut,
                              dataValidOut, buf_addr, byteEnablesOut, burstSizeOut, dbg_state}, 0);
    check("midreset_outs_b", {buf_wdata, addressDataOut}, 0);
    check("midreset_writes", exp_wr_q.size(), 0);
    clear_bus_inputs();
    exp_wr_q.delete();
    step();
    reset = 0;
    step();
    check("ready_after_midreset", cmd_ready, 1);
    check("error_after_midreset", bus_error, 0);
    read_txn(32'h00004400, 3, 0, -1, 0, 1'b0);

    // Full-buffer read: 256 beats cover buffer addresses 0..255.
    read_txn(32'h00005000, 255, 1, -1, 0, 1'b0);

    // Randomized mix.
    for (int t = 0; t < 16; t++) begin
      int burst, delay, err;
      burst = $urandom_range(0, 15);
      delay = $urandom_range(0, 4);
      err   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, burst) : -1;
      if ($urandom_range(0, 1) == 1) begin
        if (err >= 0 && err == burst && burst > 0 && $urandom_range(0, 1) == 1)
          read_txn({$urandom_range(0, 65535), 2'b00}, burst, delay, err - 1, 1, 1'b0);
        else
          read_txn({$urandom_range(0, 65535), 2'b00}, burst, delay, err, 0, 1'b0);
      end else begin
        for (int i = 0; i <= burst; i++) wdat[i] = $urandom;
        write_txn({$urandom_range(0, 65535), 2'b00}, burst, delay, err, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
